// File: rtl/ro_freq_meter.sv
// ro_freq_meter
// Counts rising edges of a free-running ring-oscillator tap over a window of
// win_len system-clock cycles and reports the (saturating) count with a
// one-cycle done pulse.
//
// Ports:
//   clk     system clock, all state on its rising edge
//   rst     asynchronous active-high reset
//   i       ring-oscillator tap, asynchronous to clk
//   start   measurement request, honoured only while idle
//   win_len window length in clk cycles, captured with an accepted start
//   busy    high while the window is open (counting cycles)
//   done    one-cycle pulse, count/ovf are final while it is high
//   count   rising edges seen in the window, saturates at all-ones
//   ovf     count saturated during the last measurement (sticky)
module ro_freq_meter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] TIMER_LAST = WIN_W'(1);

  state_t           state;
  logic [WIN_W-1:0] timer;
  logic             s1, s2, s3;
  logic             rise;

  // s1/s2 resynchronise the tap; s3 keeps the previous s2 so a rising edge
  // of the synchronised signal lasts exactly one clk cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // A zero-length request is dropped without touching the held result.
          if (start && (win_len != '0)) begin
            timer <= win_len;
            count <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            if (count == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          timer <= timer - 1'b1;
          // timer still holds the cycles left including this one, so the
          // window closes on the cycle where it reads 1.
          if (timer == TIMER_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Testbench for ro_freq_meter: drives the tap from a stimulus generator,
// records the value of the tap seen at every rising clock edge, and predicts
// each window result by counting 0->1 transitions of that recorded stream
// over the window shifted by the two-cycle synchroniser latency.
module tb_ro_freq_meter;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst, i, start;
  logic [15:0] win_len;
  logic        busy, done, ovf;
  logic [15:0] count;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  ro_freq_meter #(.CNT_W(16), .WIN_W(16)) dut (
    .clk(clk), .rst(rst), .i(i), .start(start), .win_len(win_len),
    .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  ro_freq_meter #(.CNT_W(4), .WIN_W(16)) dut_sat (
    .clk(clk), .rst(rst), .i(i), .start(start), .win_len(win_len),
    .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Tap value sampled at each rising edge, index 0 = first edge after time 5.
  bit hist[$];
  int mode = 0;  // 0 low, 1 high, 2 square wave, 3 random bits
  int hp   = 2;  // half period of the square wave in clk cycles
  int ph   = 0;

  logic        busy_s, done_s, ovf_s, busy4_s, done4_s, ovf4_s;
  logic [15:0] cnt_s;
  logic [3:0]  cnt4_s;
  int          last_cnt = 0;

  // One clock cycle: sample outputs (reflecting the previous rising edge),
  // then drive inputs for the next rising edge.
  task automatic step(input logic st, input logic [15:0] wl);
    logic nv;
    @(negedge clk);
    busy_s = busy;  done_s = done;  cnt_s = count;   ovf_s = ovf;
    busy4_s = busy4; done4_s = done4; cnt4_s = count4; ovf4_s = ovf4;
    case (mode)
      0:       nv = 1'b0;
      1:       nv = 1'b1;
      2: begin ph++; nv = ((ph / hp) % 2) == 1; end
      default: nv = 1'($urandom_range(0, 1));
    endcase
    i = nv;
    start = st;
    win_len = wl;
    hist.push_back(nv);
  endtask

  // Rising transitions of the tap between edge indices t-1 .. t+w-2: the
  // window's w counting edges see the tap as it was two edges earlier.
  function automatic int model_edges(input int t, input int w);
    int c = 0;
    for (int n = t - 1; n <= t + w - 2; n++) begin
      bit prev = (n > 0) ? hist[n-1] : 1'b0;
      if (hist[n] && !prev) c++;
    end
    return c;
  endfunction

  task automatic run(input int w, input bit noisy, input string tag);
    int t, bcyc, dcnt, e;
    bcyc = 0;
    dcnt = 0;
    step(1'b1, 16'(w));
    t = hist.size() - 1;
    check({tag, "_idle_before"}, {busy_s, done_s, busy4_s, done4_s}, 0);
    for (int k = 1; k <= w; k++) begin
      step(noisy && ($urandom_range(0, 3) == 0), 16'($urandom_range(1, 65535)));
      bcyc += int'(busy_s);
      dcnt += int'(done_s | done4_s);
      if (k == 1) check({tag, "_cleared"}, {cnt_s, ovf_s}, 0);
    end
    // This step's start lands on the DONE cycle and must be dropped.
    step(noisy, 16'($urandom_range(1, 65535)));
    check({tag, "_busy_cycles"}, bcyc, w);
    check({tag, "_done_in_window"}, dcnt, 0);
    check({tag, "_done"}, {done_s, busy_s, done4_s, busy4_s}, 4'b1010);
    e = model_edges(t, w);
    check({tag, "_count"}, cnt_s, (e > 65535) ? 65535 : e);
    check({tag, "_ovf"}, ovf_s, e > 65535);
    check({tag, "_count4"}, cnt4_s, (e > 15) ? 15 : e);
    check({tag, "_ovf4"}, ovf4_s, e > 15);
    last_cnt = (e > 65535) ? 65535 : e;
    $display("window %s: len=%0d edges=%0d count=%0d ovf=%0b count4=%0d ovf4=%0b",
             tag, w, e, cnt_s, ovf_s, cnt4_s, ovf4_s);
  endtask

  initial begin
    int bsum, dsum;
    rst = 1'b1; i = 1'b0; start = 1'b0; win_len = '0;
    #1;
    check("reset_outputs", {busy, done, ovf, count}, 0);
    check("reset_outputs4", {busy4, done4, ovf4, count4}, 0);
    repeat (3) step(1'b0, '0);
    rst = 1'b0;
    repeat (4) step(1'b0, '0);

    // Nominal: period-4 square wave over 100 cycles.
    mode = 2; hp = 2; ph = 0;
    repeat (4) step(1'b0, '0);
    run(100, 1'b0, "nominal");
    check("nominal_25", cnt_s, 25);

    // Saturation of the 4-bit instance, then a back-to-back short window.
    hp = 1;
    run(40, 1'b0, "sat");
    check("sat_count4_15", {ovf4_s, cnt4_s}, 5'h1f);
    run(10, 1'b0, "sat_short");
    check("sat_short_5", {ovf4_s, cnt4_s}, 5'h05);

    run(1, 1'b0, "w1");

    // Static input, low then high after the synchroniser settles.
    mode = 0;
    repeat (4) step(1'b0, '0);
    run(50, 1'b0, "static0");
    check("static0_zero", cnt_s, 0);
    mode = 1;
    repeat (4) step(1'b0, '0);
    run(50, 1'b0, "static1");
    check("static1_zero", cnt_s, 0);

    // Zero-length request is ignored and the held result survives.
    mode = 2; hp = 2;
    step(1'b1, '0);
    bsum = 0; dsum = 0;
    repeat (5) begin
      step(1'b0, '0);
      bsum += int'(busy_s | busy4_s);
      dsum += int'(done_s | done4_s);
    end
    check("zero_len_busy", bsum, 0);
    check("zero_len_done", dsum, 0);
    check("zero_len_hold", cnt_s, last_cnt);

    // Starts sprinkled through the window and on the DONE cycle.
    hp = 3;
    run(30, 1'b1, "noisy");

    // Asynchronous reset in the middle of a window.
    hp = 2;
    repeat (2) step(1'b0, '0);
    step(1'b1, 16'd100);
    repeat (40) step(1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {busy, done, ovf, count}, 0);
    check("midrst_outputs4", {busy4, done4, ovf4, count4}, 0);
    dsum = 0;
    repeat (2) begin
      step(1'b0, '0);
      dsum += int'(done_s | done4_s | busy_s);
    end
    rst = 1'b0;
    repeat (4) begin
      step(1'b0, '0);
      dsum += int'(done_s | done4_s | busy_s);
    end
    check("midrst_no_done", dsum, 0);
    run(20, 1'b0, "post_rst");
    check("post_rst_5", cnt_s, 5);

    // Randomised windows.
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 3);
      hp = $urandom_range(1, 4);
      run($urandom_range(1, 60), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end
    step(1'b0, '0);
    check("final_idle", {busy_s, done_s, busy4_s, done4_s}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
